// File: rtl/vga_sched_pkg.sv
// Package: vga_sched_pkg
// Shared definitions for the VGA draw scheduler: FSM state encoding,
// default screen dimensions and the transparent colour key.
// No ports (package only).
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  // Magenta is reserved as the "see-through" sprite colour.
  localparam logic [2:0] KEY_COLOUR = 3'b101;

endpackage

// File: rtl/vga_draw_scheduler_rr_arbiter.sv
// Module: rr_arbiter
// Purely combinational round-robin pick: the first set request bit at or
// after ptr, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req   in  NUM_REQ          request vector
//   ptr   in  clog2(NUM_REQ)   highest-priority index this round
//   grant out NUM_REQ          one-hot winner (0 when no request)
//   idx   out clog2(NUM_REQ)   winner index
//   valid out 1                any request present
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Module: vga_draw_scheduler
// Shares the single vga_adapter write port among NUM_REQ requesters. A
// round-robin winner is picked in IDLE, its rectangle is swept row by row
// in DRAW (one pixel address per cycle into the shared ROM), and FLUSH
// plots the final pixel that is still in the one-stage plot pipeline.
// Optional build macro: VGA_SCHED_TRANSPARENCY_EN suppresses plots of
// KEY_COLOUR pixels so sprites overlay the background.
//
// state | meaning
// IDLE  | arbitrate; latch winner geometry, clear row/col
// DRAW  | issue one ROM address {row, col} per cycle
// FLUSH | last pixel leaves the pipeline; done pulses, grant drops
//
// Ports:
//   CLOCK_50, reset (async, active-high)
//   req, req_x, req_y, req_wm1, req_hm1, pix_colour   per-requester inputs
//   mem_addr   shared ROM address {row, col}
//   grant      one-hot, held for the whole draw
//   done       one-cycle pulse with the last plot
//   busy       high in DRAW or FLUSH
//   vga_x, vga_y, vga_colour, vga_plot   vga_adapter write port
module vga_draw_scheduler
  import vga_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DIM_BITS = 3,
  parameter int SCR_W    = SCR_W_DEF,
  parameter int SCR_H    = SCR_H_DEF
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*8-1:0]         req_x,
  input  logic [NUM_REQ*7-1:0]         req_y,
  input  logic [NUM_REQ*DIM_BITS-1:0]  req_wm1,
  input  logic [NUM_REQ*DIM_BITS-1:0]  req_hm1,
  input  logic [NUM_REQ*3-1:0]         pix_colour,
  output logic [2*DIM_BITS-1:0]        mem_addr,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [7:0]                   vga_x,
  output logic [6:0]                   vga_y,
  output logic [2:0]                   vga_colour,
  output logic                         vga_plot
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [8:0] SCR_W_L = 9'(SCR_W);
  localparam logic [7:0] SCR_H_L = 8'(SCR_H);

  sched_state_t state, next_state;

  logic [IDX_W-1:0]    ptr, idx_r, idx_d, arb_idx;
  logic [NUM_REQ-1:0]  arb_grant, grant_r;
  logic                arb_valid;
  logic [7:0]          x0;
  logic [6:0]          y0;
  logic [DIM_BITS-1:0] wm1, hm1, row, col, row_d, col_d;
  logic                valid_d;
  logic [7:0]          x_hold;
  logic [6:0]          y_hold;
  logic [2:0]          c_hold;
  logic [8:0]          sum_x;
  logic [7:0]          sum_y;
  logic [2:0]          pix_sel;
  logic                clipped, transparent;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    grant      = '0;
    done       = '0;
    mem_addr   = {row, col};
    case (state)
      IDLE: begin
        if (arb_valid) next_state = DRAW;
      end
      DRAW: begin
        busy  = 1'b1;
        grant = grant_r;
        if (row == hm1 && col == wm1) next_state = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        grant      = grant_r;
        done       = grant_r;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      idx_r   <= '0;
      grant_r <= '0;
      x0      <= '0;
      y0      <= '0;
      wm1     <= '0;
      hm1     <= '0;
      row     <= '0;
      col     <= '0;
      valid_d <= 1'b0;
      row_d   <= '0;
      col_d   <= '0;
      idx_d   <= '0;
      x_hold  <= '0;
      y_hold  <= '0;
      c_hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            idx_r   <= arb_idx;
            grant_r <= arb_grant;
            x0      <= req_x[int'(arb_idx)*8 +: 8];
            y0      <= req_y[int'(arb_idx)*7 +: 7];
            wm1     <= req_wm1[int'(arb_idx)*DIM_BITS +: DIM_BITS];
            hm1     <= req_hm1[int'(arb_idx)*DIM_BITS +: DIM_BITS];
            row     <= '0;
            col     <= '0;
            ptr     <= (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + IDX_W'(1);
          end
        end
        DRAW: begin
          if (col == wm1) begin
            col <= '0;
            row <= row + DIM_BITS'(1);
          end else begin
            col <= col + DIM_BITS'(1);
          end
        end
        default: ;
      endcase

      // One pipeline stage matches the synchronous ROM read latency.
      valid_d <= (state == DRAW);
      row_d   <= row;
      col_d   <= col;
      idx_d   <= idx_r;

      if (vga_plot) begin
        x_hold <= sum_x[7:0];
        y_hold <= sum_y[6:0];
        c_hold <= pix_sel;
      end
    end
  end

  // Sums are one bit wider so off-screen pixels are clipped, not wrapped.
  // x0/y0 stay stable through FLUSH, so the last pixel still sees them.
  always_comb begin
    sum_x   = {1'b0, x0} + 9'(col_d);
    sum_y   = {1'b0, y0} + 8'(row_d);
    pix_sel = pix_colour[int'(idx_d)*3 +: 3];
    clipped = (sum_x >= SCR_W_L) || (sum_y >= SCR_H_L);
`ifdef VGA_SCHED_TRANSPARENCY_EN
    transparent = (pix_sel == KEY_COLOUR);
`else
    transparent = 1'b0;
`endif
    vga_plot   = valid_d && !clipped && !transparent;
    vga_x      = vga_plot ? sum_x[7:0] : x_hold;
    vga_y      = vga_plot ? sum_y[6:0] : y_hold;
    vga_colour = vga_plot ? pix_sel    : c_hold;
  end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Testbench for vga_draw_scheduler: directed and randomized draws checked
// cycle by cycle against a rectangle/round-robin reference model.
module tb_vga_draw_scheduler;

  localparam int NR = 4;
  localparam int DB = 3;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*8-1:0]   req_x;
  logic [NR*7-1:0]   req_y;
  logic [NR*DB-1:0]  req_wm1;
  logic [NR*DB-1:0]  req_hm1;
  logic [NR*3-1:0]   pix_colour;
  logic [2*DB-1:0]   mem_addr;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;
  logic              vga_plot;

  vga_draw_scheduler #(.NUM_REQ(NR), .DIM_BITS(DB), .SCR_W(160), .SCR_H(120)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_wm1    (req_wm1),
    .req_hm1    (req_hm1),
    .pix_colour (pix_colour),
    .mem_addr   (mem_addr),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Requester i's ROM: colour = addr[2:0] ^ (i ^ 2), so requester 2 returns addr[2:0].
  function automatic logic [2:0] rom_val(input int i, input logic [5:0] a);
    logic [2:0] k;
    k = 3'(i ^ 2);
    return a[2:0] ^ k;
  endfunction

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) pix_colour <= '0;
    else for (int i = 0; i < NR; i++) pix_colour[i*3 +: 3] <= rom_val(i, mem_addr);
  end

  int n_checks = 0;
  int n_errors = 0;

  int m_ptr;
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [2:0] last_c;
  int gx[NR], gy[NR], gw[NR], gh[NR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_geom();
    for (int i = 0; i < NR; i++) begin
      req_x[i*8 +: 8]     = 8'(gx[i]);
      req_y[i*7 +: 7]     = 7'(gy[i]);
      req_wm1[i*DB +: DB] = DB'(gw[i]);
      req_hm1[i*DB +: DB] = DB'(gh[i]);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] m);
    int j;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (m[j]) return j;
    end
    return 0;
  endfunction

  // One complete draw: arbitration cycle, every DRAW cycle, FLUSH, and the
  // following IDLE cycle are each checked. Model: pixel p plots 2 cycles
  // after req is sampled plus p, in row-major order.
  task automatic run_draw(input logic [NR-1:0] mask, input bit hold);
    int w, wd, n, p, r, c, sx, sy, ar;
    bit pl;
    logic [2:0] col;
    logic [NR-1:0] oh;
    w  = pick(mask);
    wd = gw[w] + 1;
    n  = wd * (gh[w] + 1);
    oh = NR'(1) << w;
    drive_geom();
    req = mask;
    m_ptr = (w + 1) % NR;
    for (int k = 1; k <= n + 2; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (k == 1 && !hold) begin
        req     = '0;
        req_x   = $urandom;
        req_y   = 28'($urandom);
        req_wm1 = 12'($urandom);
        req_hm1 = 12'($urandom);
      end
      p  = k - 2;
      pl = 1'b0;
      if (p >= 0 && p < n) begin
        r   = p / wd;
        c   = p % wd;
        sx  = gx[w] + c;
        sy  = gy[w] + r;
        col = rom_val(w, 6'(r * 8 + c));
        pl  = (sx < 160) && (sy < 120);
`ifdef VGA_SCHED_TRANSPARENCY_EN
        if (col == 3'b101) pl = 1'b0;
`endif
        if (pl) begin
          last_x = 8'(sx);
          last_y = 7'(sy);
          last_c = col;
        end
      end
      check("plot", {31'b0, vga_plot}, {31'b0, pl});
      check("x", {24'b0, vga_x}, {24'b0, last_x});
      check("y", {25'b0, vga_y}, {25'b0, last_y});
      check("colour", {29'b0, vga_colour}, {29'b0, last_c});
      check("grant", {28'b0, grant}, (k <= n + 1) ? {28'b0, oh} : 32'd0);
      check("busy", {31'b0, busy}, (k <= n + 1) ? 32'd1 : 32'd0);
      check("done", {28'b0, done}, (k == n + 1) ? {28'b0, oh} : 32'd0);
      if (k <= n) begin
        ar = ((k - 1) / wd) * 8 + (k - 1) % wd;
        check("addr", {26'b0, mem_addr}, 32'(ar));
      end
    end
    req = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, {28'b0, grant}, 32'd0);
    check({tag, "_done"}, {28'b0, done}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_plot"}, {31'b0, vga_plot}, 32'd0);
    check({tag, "_x"}, {24'b0, vga_x}, 32'd0);
    check({tag, "_y"}, {25'b0, vga_y}, 32'd0);
    check({tag, "_colour"}, {29'b0, vga_colour}, 32'd0);
    check({tag, "_addr"}, {26'b0, mem_addr}, 32'd0);
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    last_x = '0;
    last_y = '0;
    last_c = '0;
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_x   = '0;
    req_y   = '0;
    req_wm1 = '0;
    req_hm1 = '0;
    for (int i = 0; i < NR; i++) begin
      gx[i] = 0; gy[i] = 0; gw[i] = 0; gh[i] = 0;
    end
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // 2x2 draw at (10,20) on requester 0
    gx[0] = 10; gy[0] = 20; gw[0] = 1; gh[0] = 1;
    run_draw(4'b0001, 1'b0);

    // Round-robin between requesters 0 and 1 with 1x1 sprites held high
    gx[0] = 5;  gy[0] = 6;  gw[0] = 0; gh[0] = 0;
    gx[1] = 70; gy[1] = 80; gw[1] = 0; gh[1] = 0;
    repeat (4) run_draw(4'b0011, 1'b1);

    // Right-edge clip
    gx[1] = 158; gy[1] = 0; gw[1] = 3; gh[1] = 0;
    run_draw(4'b0010, 1'b0);

    // Colour pipeline on requester 2
    gx[2] = int'($urandom_range(0, 150)); gy[2] = int'($urandom_range(0, 110));
    gw[2] = 7; gh[2] = int'($urandom_range(1, 7));
    run_draw(4'b0100, 1'b0);

    // Row containing the magenta key (col 5 on requester 2)
    gx[2] = 0; gy[2] = 0; gw[2] = 7; gh[2] = 0;
    run_draw(4'b0100, 1'b0);

    // Randomized draws, including clipped and bottom-edge geometry
    repeat (16) begin
      for (int i = 0; i < NR; i++) begin
        gx[i] = int'($urandom_range(0, 200));
        gy[i] = int'($urandom_range(0, 127));
        gw[i] = int'($urandom_range(0, 7));
        gh[i] = int'($urandom_range(0, 7));
      end
      run_draw(NR'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

    // Reset in row 1 of an 8x8 draw
    gx[0] = 20; gy[0] = 30; gw[0] = 7; gh[0] = 7;
    drive_geom();
    req = 4'b0001;
    repeat (10) @(posedge CLOCK_50);
    #1;
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    req   = '0;
    #1;
    check_zero("midreset");
    @(posedge CLOCK_50);
    #1;
    check("reset_hold_done", {28'b0, done}, 32'd0);
    reset = 1'b0;
    model_reset();
    gx[3] = 40; gy[3] = 50; gw[3] = 2; gh[3] = 1;
    run_draw(4'b1000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_draw_scheduler.md
Name: vga_draw_scheduler

Overview:
Shares the single vga_adapter write port (x, y, colour, plot) among NUM_REQ sprite/screen requesters such as the title/win/lose screens, the car and the obstacles. It picks one requester round-robin and sweeps a rectangle of the requested size at the requested origin. Each pixel's colour comes from the granted requester's synchronous ROM, addressed {row, col}. The block sits between the game logic/screen FSM and vga_adapter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIM_BITS, 3, bits of rectangle row/col counters; max sprite 2^DIM_BITS square
SCR_W, 160, screen width; pixels with x >= SCR_W are clipped
SCR_H, 120, screen height; pixels with y >= SCR_H are clipped

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  level request per requester
req_x  in  NUM_REQ*8  origin x per requester (slice i = bits [8i+7:8i])
req_y  in  NUM_REQ*7  origin y per requester
req_wm1  in  NUM_REQ*DIM_BITS  width minus one
req_hm1  in  NUM_REQ*DIM_BITS  height minus one
pix_colour  in  NUM_REQ*3  ROM read data per requester, valid 1 cycle after mem_addr
mem_addr  out  2*DIM_BITS  shared ROM address {row, col}
grant  out  NUM_REQ  one-hot; high for the whole draw
done  out  NUM_REQ  one-cycle pulse when the draw completes
busy  out  1  high in DRAW or FLUSH
vga_x  out  8  to vga_adapter x
vga_y  out  7  to vga_adapter y
vga_colour  out  3  to vga_adapter colour
vga_plot  out  1  to vga_adapter plot

Behaviour:
- Reset values: all outputs 0. FSM = IDLE. RR pointer = 0, so req[0] has top priority first.
- Reset takes effect asynchronously at any time, including mid-draw; the interrupted draw is abandoned and gets no done pulse.
- IDLE state:
  - If req != 0, grant the first set bit at or after the pointer, wrapping.
  - Latch that requester's x, y, wm1 and hm1; set row = col = 0; move to DRAW.
  - Set the pointer to the winner+1 mod NUM_REQ.
- DRAW state:
  - grant is asserted from the first DRAW cycle; mem_addr = {row, col}.
  - Each cycle col++. When col == wm1, col resets to 0 and row++.
  - When row == hm1 and col == wm1, move to FLUSH.
- FLUSH state (one cycle): plots the final pixel. At the end of this cycle done[i] pulses together with the last plot, grant drops, and the FSM returns to IDLE.
- Plot pipeline (1-cycle latency):
  - The address, the pixel coordinates and the requester index are registered one stage.
  - vga_x = X0 + col_d and vga_y = Y0 + row_d, computed at 9/8-bit width.
  - vga_colour = pix_colour slice of the granted requester, selected by the delayed index.
  - vga_plot is high in the cycle after each DRAW cycle, unless the pixel is clipped.
  - vga_x, vga_y and vga_colour hold their last values when vga_plot = 0.
- Clipping: if the full-width sum is >= SCR_W or >= SCR_H, vga_plot = 0 for that pixel and its x/y are not wrapped. The sweep still runs for the full rectangle.
- Timing:
  - One draw occupies (wm1+1)*(hm1+1) DRAW cycles + 1 FLUSH cycle + 1 IDLE arbitration cycle.
  - First plot is 2 cycles after req is sampled.
- Request rules:
  - req is sampled only in IDLE.
  - Dropping req mid-draw does not abort the draw.
  - Geometry changes mid-draw are ignored (latched values are used).
  - A requester still holding req after done is re-arbitrated fairly.
- Degenerate case: wm1 = hm1 = 0 gives 1 DRAW + 1 FLUSH cycle and exactly one plot.

Optional Feature:
VGA_SCHED_TRANSPARENCY_EN
- Defined: a pixel whose colour is 3'b101 (magenta key) gets vga_plot = 0; sprites overlay the background.
- Undefined: every unclipped pixel is plotted, including magenta.

Decomposition:
- Package vga_sched_pkg holds:
  - the FSM state encoding IDLE/DRAW/FLUSH
  - SCR_W/SCR_H defaults
  - the transparent key constant 3'b101
- Sub-module rr_arbiter (NUM_REQ): req + pointer in, one-hot grant and index out, purely combinational. The scheduler instantiates it once and holds the pointer register itself.

Test Plan:
1. Single 2x2 draw: req[0]=1, x=10, y=20, wm1=hm1=1 → plots (10,20), (11,20), (10,21), (11,21) on 4 consecutive cycles starting 2 cycles after req; done[0] pulses with the (11,21) plot; grant[0] high 5 cycles.
2. Round-robin: req[0] and req[1] held high, 1x1 sprites → grant order 0,1,0,1; never two consecutive grants to the same requester while the other waits.
3. Right-edge clip: x=158, y=0, wm1=3, hm1=0 → plots at x=158,159 only; done still pulses after 4 DRAW cycles.
4. Colour pipeline: requester 2's ROM returns colour = addr[2:0] → each plot's vga_colour matches the address issued one cycle earlier.
5. Reset mid-draw: assert reset during row 1 of an 8x8 draw → all outputs 0 immediately, no done pulse; after release req[3] alone is granted.
6. With VGA_SCHED_TRANSPARENCY_EN: a ROM pixel equal to 3'b101 → no plot at that coordinate; without the macro → plotted with colour 3'b101.
